voice_synth: RTL and testbench



---
 rtl/music_pkg.sv | 19 +
 rtl/voice_synth_if.sv | 18 +
 rtl/voice_mix_acc.sv | 65 ++++++
 rtl/voice_synth.sv | 111 +++++++++++
 tb/tb_voice_synth.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared music constants and the slot index type used by the sequencer and voice_synth.
package music_pkg;

    localparam int NUM_SLOTS      = 4;
    localparam int CELLO_AMP_DEF  = 64;
    localparam int VIOLIN_AMP_DEF = 48;

    typedef logic [1:0] slot_t;

    function automatic int voice_amp(input slot_t s, input int cello_amp, input int violin_amp);
        int amp;
        case (s)
            2'd0:    amp = cello_amp;
            default: amp = violin_amp;
        endcase
        return amp;
    endfunction

endpackage

// File: rtl/voice_synth_if.sv
// Sequencer-facing bus of voice_synth: slot/divider/enable in, mixed sample and tone bits out.
interface voice_synth_if #(
    parameter int DIV_W    = 11,
    parameter int SAMPLE_W = 8
);
    import music_pkg::*;

    slot_t                slot;
    logic [DIV_W-1:0]     divider;
    logic                 enable;
    logic [SAMPLE_W-1:0]  sample;
    logic                 sample_valid;
    logic [NUM_SLOTS-1:0] tones;

    modport master (output slot, divider, enable, input sample, sample_valid, tones);
    modport slave  (input slot, divider, enable, output sample, sample_valid, tones);

endinterface

// File: rtl/voice_mix_acc.sv
// Frame accumulator for voice_synth: sums slot contributions, saturates and registers the sample.
module voice_mix_acc
    import music_pkg::*;
#(
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  slot_t               slot,
    input  logic [SAMPLE_W-1:0] contrib,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid
);

    localparam int ACC_W = SAMPLE_W + 1;
    localparam logic [ACC_W:0] SAT_MAX = {2'b00, {SAMPLE_W{1'b1}}};

    logic [ACC_W-1:0] acc_r;
    logic             armed_r;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_nxt_s;

    function automatic logic [SAMPLE_W-1:0] sat(input logic [ACC_W:0] v);
        logic [SAMPLE_W-1:0] r;
        if (v > SAT_MAX) begin
            r = {SAMPLE_W{1'b1}};
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

    // Running sum; clamps at the accumulator ceiling so repeated out-of-order visits cannot wrap.
    always_comb begin
        sum_s     = {1'b0, acc_r} + {2'b00, contrib};
        acc_nxt_s = '0;
        if (slot == 2'd0) begin
            acc_nxt_s = {1'b0, contrib};
        end else if (sum_s[ACC_W]) begin
            acc_nxt_s = {ACC_W{1'b1}};
        end else begin
            acc_nxt_s = sum_s[ACC_W-1:0];
        end
    end

    // armed_r blocks sample updates until a slot-0 visit has started a fresh frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r        <= '0;
            armed_r      <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            acc_r        <= acc_nxt_s;
            sample_valid <= (slot == 2'd3) && armed_r;
            if (slot == 2'd0) begin
                armed_r <= 1'b1;
            end
            if ((slot == 2'd3) && armed_r) begin
                sample <= sat(sum_s);
            end
        end
    end

endmodule

// File: rtl/voice_synth.sv
// Time-multiplexed four-voice square-wave oscillator bank with frame mixer.
// Optional macro VOICE_SYNTH_RETRIGGER_EN restarts a voice (tone high) whenever its divider changes.
module voice_synth
    import music_pkg::*;
#(
    parameter int DIV_W      = 11,
    parameter int SAMPLE_W   = 8,
    parameter int CELLO_AMP  = CELLO_AMP_DEF,
    parameter int VIOLIN_AMP = VIOLIN_AMP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    voice_synth_if.slave bus
);

    logic [DIV_W-1:0]     cnt_r [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] tone_r;
    logic [DIV_W-1:0]     cnt_cur_s;
    logic [DIV_W-1:0]     cnt_nxt_s;
    logic                 tone_cur_s;
    logic                 tone_nxt_s;
    logic                 div_zero_s;
    logic                 retrig_s;
    logic [SAMPLE_W-1:0]  contrib_s;

    // Serviced slot's stored state and its contribution, taken from the pre-update tone.
    always_comb begin
        cnt_cur_s  = cnt_r[bus.slot];
        tone_cur_s = tone_r[bus.slot];
        div_zero_s = (bus.divider == '0);
        if (bus.enable && tone_cur_s && !div_zero_s) begin
            contrib_s = SAMPLE_W'(voice_amp(bus.slot, CELLO_AMP, VIOLIN_AMP));
        end else begin
            contrib_s = '0;
        end
    end

`ifdef VOICE_SYNTH_RETRIGGER_EN
    logic [DIV_W-1:0] last_div_r [NUM_SLOTS];

    // A divider differing from the one seen on the previous visit marks a note onset.
    always_comb begin
        retrig_s = (bus.divider != last_div_r[bus.slot]);
    end

    // Divider history, refreshed on every visit of a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                last_div_r[i] <= '0;
            end
        end else begin
            last_div_r[bus.slot] <= bus.divider;
        end
    end
`else
    // Without retrigger the phase simply carries across divider changes.
    always_comb begin
        retrig_s = 1'b0;
    end
`endif

    // Oscillator step; >= lets a shrinking divider wrap at once instead of counting through 2^DIV_W.
    always_comb begin
        cnt_nxt_s  = cnt_cur_s;
        tone_nxt_s = tone_cur_s;
        if (!bus.enable) begin
            cnt_nxt_s  = cnt_cur_s;
            tone_nxt_s = tone_cur_s;
        end else if (div_zero_s) begin
            cnt_nxt_s  = '0;
            tone_nxt_s = 1'b0;
        end else if (retrig_s) begin
            cnt_nxt_s  = '0;
            tone_nxt_s = 1'b1;
        end else if (cnt_cur_s >= (bus.divider - DIV_W'(1))) begin
            cnt_nxt_s  = '0;
            tone_nxt_s = ~tone_cur_s;
        end else begin
            cnt_nxt_s  = cnt_cur_s + DIV_W'(1);
            tone_nxt_s = tone_cur_s;
        end
    end

    // Per-slot phase counters and tone bits; only the serviced slot is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cnt_r[i] <= '0;
            end
            tone_r <= '0;
        end else begin
            cnt_r[bus.slot]  <= cnt_nxt_s;
            tone_r[bus.slot] <= tone_nxt_s;
        end
    end

    assign bus.tones = tone_r;

    voice_mix_acc #(
        .SAMPLE_W (SAMPLE_W)
    ) u_mix (
        .clk          (clk),
        .rst          (rst),
        .slot         (bus.slot),
        .contrib      (contrib_s),
        .sample       (bus.sample),
        .sample_valid (bus.sample_valid)
    );

endmodule

// File: tb/tb_voice_synth.sv
// Self-checking bench for voice_synth: two instances (violin amplitude 48 and 80) share stimulus
// and are compared each cycle against a frame-level reference model.
module tb_voice_synth;
    import music_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    voice_synth_if #(.DIV_W(11), .SAMPLE_W(8)) bus ();
    voice_synth_if #(.DIV_W(11), .SAMPLE_W(8)) bus_sat ();

    voice_synth #(.DIV_W(11), .SAMPLE_W(8), .CELLO_AMP(64), .VIOLIN_AMP(48)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    voice_synth #(.DIV_W(11), .SAMPLE_W(8), .CELLO_AMP(64), .VIOLIN_AMP(80)) dut_sat (
        .clk (clk), .rst (rst), .bus (bus_sat)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         m_cnt [4];
    int         m_last [4];
    logic [3:0] m_tones;
    int         m_sum_n, m_sum_s;
    bit         m_armed;
    int         e_samp_n, e_samp_s;
    bit         e_valid;

    function automatic void model_edge(input int s, input int d, input bit en, input bit r);
        int  cn, cs;
        bit  audible;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]  = 0;
                m_last[i] = 0;
            end
            m_tones  = '0;
            m_sum_n  = 0;
            m_sum_s  = 0;
            m_armed  = 1'b0;
            e_samp_n = 0;
            e_samp_s = 0;
            e_valid  = 1'b0;
            return;
        end
        audible = en && m_tones[s] && (d != 0);
        cn = audible ? ((s == 0) ? 64 : 48) : 0;
        cs = audible ? ((s == 0) ? 64 : 80) : 0;
        if (s == 0) begin
            m_sum_n = cn;
            m_sum_s = cs;
        end else begin
            m_sum_n += cn;
            m_sum_s += cs;
        end
        e_valid = (s == 3) && m_armed;
        if (e_valid) begin
            e_samp_n = (m_sum_n > 255) ? 255 : m_sum_n;
            e_samp_s = (m_sum_s > 255) ? 255 : m_sum_s;
        end
        if (s == 0) m_armed = 1'b1;
        if (en) begin
            if (d == 0) begin
                m_cnt[s] = 0;
                m_tones[s] = 1'b0;
            end
`ifdef VOICE_SYNTH_RETRIGGER_EN
            else if (d != m_last[s]) begin
                m_cnt[s] = 0;
                m_tones[s] = 1'b1;
            end
`endif
            else if (m_cnt[s] >= d - 1) begin
                m_cnt[s] = 0;
                m_tones[s] = ~m_tones[s];
            end else begin
                m_cnt[s] = m_cnt[s] + 1;
            end
        end
        m_last[s] = d;
    endfunction

    function automatic logic [21:0] exp_vec();
        return {8'(e_samp_n), 8'(e_samp_s), e_valid, e_valid, m_tones};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {bus.sample, bus_sat.sample, bus.sample_valid, bus_sat.sample_valid, bus.tones};
    endfunction

    task automatic drive(input int s, input int d, input bit en, input bit r);
        bus.slot        = 2'(s);
        bus.divider     = 11'(d);
        bus.enable      = en;
        bus_sat.slot    = 2'(s);
        bus_sat.divider = 11'(d);
        bus_sat.enable  = en;
        rst             = r;
        @(posedge clk);
        model_edge(s, d, en, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 2047), 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (obs_vec() !== 22'd0) begin
                errors++;
                $display("FAIL reset cyc%0d got %h exp %h", i, obs_vec(), 22'd0);
            end
        end
    endtask

    task automatic test_cello();
        int got[$];
        drive(0, 0, 1'b1, 1'b1);
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < 4; s++) begin
                drive(s, (s == 0) ? 2 : 0, 1'b1, 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL cello f%0d s%0d got %h exp %h", f, s, obs_vec(), exp_vec());
                end
                if (s == 3) got.push_back(int'(bus.sample));
            end
        end
`ifndef VOICE_SYNTH_RETRIGGER_EN
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== (((k % 4) >= 2) ? 64 : 0)) begin
                errors++;
                $display("FAIL cello_seq frame%0d got %0d exp %0d", k, got[k], ((k % 4) >= 2) ? 64 : 0);
            end
        end
`endif
    endtask

    task automatic test_all_high();
        drive(0, 0, 1'b1, 1'b1);
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < 4; s++) begin
                drive(s, 1, 1'b1, 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL all_high f%0d s%0d got %h exp %h", f, s, obs_vec(), exp_vec());
                end
            end
`ifndef VOICE_SYNTH_RETRIGGER_EN
            checks++;
            if (bus_sat.sample !== ((f % 2 == 1) ? 8'd255 : 8'd0)) begin
                errors++;
                $display("FAIL sat_alt frame%0d got %0d exp %0d", f, bus_sat.sample, (f % 2 == 1) ? 255 : 0);
            end
`endif
        end
    endtask

    task automatic test_divider_drop();
        drive(0, 0, 1'b1, 1'b1);
        for (int f = 0; f < 72; f++) begin
            for (int s = 0; s < 4; s++) begin
                drive(s, (s == 1) ? ((f < 60) ? 100 : 10) : 0, 1'b1, 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL div_drop f%0d s%0d got %h exp %h", f, s, obs_vec(), exp_vec());
                end
                if (s == 1 && (f == 60 || f == 69 || f == 70)) begin
                    checks++;
                    if (bus.tones[1] !== ((f == 70) ? 1'b0 : 1'b1)) begin
                        errors++;
                        $display("FAIL div_drop_tone visit%0d got %b exp %b", f - 59, bus.tones[1], (f == 70) ? 1'b0 : 1'b1);
                    end
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [3:0] frozen;
        drive(0, 0, 1'b1, 1'b1);
        frozen = '0;
        for (int f = 0; f < 12; f++) begin
            if (f == 5) frozen = bus.tones;
            for (int s = 0; s < 4; s++) begin
                drive(s, (s == 0) ? 3 : ((s == 2) ? 2 : 0), !(f == 5 || f == 6), 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL enable f%0d s%0d got %h exp %h", f, s, obs_vec(), exp_vec());
                end
            end
            if (f == 5 || f == 6) begin
                checks++;
                if ({bus.tones, bus.sample, bus_sat.sample} !== {frozen, 16'd0}) begin
                    errors++;
                    $display("FAIL enable_freeze f%0d got %h exp %h", f, {bus.tones, bus.sample, bus_sat.sample}, {frozen, 16'd0});
                end
            end
        end
    endtask

    task automatic test_retrigger();
        drive(0, 0, 1'b1, 1'b1);
        for (int f = 0; f < 26; f++) begin
            for (int s = 0; s < 4; s++) begin
                drive(s, (s == 2) ? ((f < 20) ? 50 : 40) : 0, 1'b1, 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL retrig f%0d s%0d got %h exp %h", f, s, obs_vec(), exp_vec());
                end
                if (f == 20 && s == 2) begin
                    checks++;
`ifdef VOICE_SYNTH_RETRIGGER_EN
                    if (bus.tones[2] !== 1'b1) begin
                        errors++;
                        $display("FAIL retrig_tone got %b exp 1", bus.tones[2]);
                    end
`else
                    if (bus.tones[2] !== 1'b0) begin
                        errors++;
                        $display("FAIL retrig_tone got %b exp 0", bus.tones[2]);
                    end
`endif
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        drive(0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) drive(i % 4, 1, 1'b1, 1'b0);
        drive(0, 1, 1'b1, 1'b0);
        drive(1, 1, 1'b1, 1'b1);
        drive(2, 1, 1'b1, 1'b0);
        drive(3, 1, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_partial got %h exp %h", obs_vec(), exp_vec());
        end
        for (int s = 0; s < 4; s++) drive(s, 1, 1'b1, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_full got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int s;
        s = 0;
        drive(0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 800; i++) begin
            s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : (s + 1) % 4;
            drive(s, $urandom_range(0, 6), ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d slot%0d got %h exp %h", i, s, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.slot = 2'd0;     bus.divider = 11'd0;     bus.enable = 1'b0;
        bus_sat.slot = 2'd0; bus_sat.divider = 11'd0; bus_sat.enable = 1'b0;
        model_edge(0, 0, 1'b0, 1'b1);
        test_reset();
        test_cello();
        test_all_high();
        test_divider_drop();
        test_enable();
        test_retrigger();
        test_midframe_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
